// File: rtl/hack_program_loader.sv
// hack_program_loader: streams a byte-wide program image into the instruction
// ROM, packing bytes big-endian into DATA_W-bit words written from address 0.
// The CPU is held in reset while loading and for RST_HOLD cycles afterwards.
// Optional feature macro: CHECKSUM_EN (image checksum compared against exp_sum).
module hack_program_loader #(
  parameter int DATA_W   = 16,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 16384,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [DATA_W-1:0] exp_sum,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              rom_we,
  output logic              rom_sel,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   words_loaded,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam int BPW    = DATA_W / BYTE_W;
  localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(RST_HOLD - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    byte_cnt_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [DATA_W-1:0]   acc_r;

  logic                start_s;
  logic                accept_s;
  logic                word_done_s;
  logic                overflow_s;
  logic                chk_bad_s;
  logic                fail_s;
  logic [DATA_W-1:0]   word_s;
  logic [DATA_W-1:0]   sum_next_s;
  logic                unused_s;

  // exp_sum only matters when the checksum feature is built in
  assign unused_s = ^exp_sum;

  // Byte acceptance, word assembly and end-of-image decisions
  always_comb begin
    start_s     = load_start && (state_r != LOAD);
    accept_s    = in_valid && in_ready && (state_r == LOAD);
    word_done_s = accept_s && (in_last || (byte_cnt_r == LAST_BYTE));
    // words_loaded doubles as the next word index; it saturates at DEPTH
    overflow_s  = (words_loaded >= DEPTH_L);
    word_s      = acc_r;
    for (int k = 0; k < BPW; k++) begin
      if (byte_cnt_r == CNT_W'(k)) begin
        word_s[DATA_W-1-k*BYTE_W -: BYTE_W] = in_data;
      end else begin
        word_s[DATA_W-1-k*BYTE_W -: BYTE_W] = acc_r[DATA_W-1-k*BYTE_W -: BYTE_W];
      end
    end
`ifdef CHECKSUM_EN
    sum_next_s = overflow_s ? checksum : (checksum + word_s);
    chk_bad_s  = in_last && (sum_next_s != exp_sum);
`else
    sum_next_s = {DATA_W{1'b0}};
    chk_bad_s  = 1'b0;
`endif
    fail_s = err || overflow_s || chk_bad_s;
  end

  // Loader FSM with registered ROM, handshake and CPU-reset outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      byte_cnt_r   <= '0;
      hold_cnt_r   <= '0;
      acc_r        <= '0;
      in_ready     <= 1'b0;
      rom_addr     <= '0;
      rom_data     <= '0;
      rom_we       <= 1'b0;
      rom_sel      <= 1'b0;
      cpu_rst      <= 1'b1;
      words_loaded <= '0;
      err          <= 1'b0;
      checksum     <= '0;
    end else begin
      rom_we <= 1'b0;
      if (start_s) begin
        state_r      <= LOAD;
        in_ready     <= 1'b1;
        rom_sel      <= 1'b1;
        cpu_rst      <= 1'b1;
        byte_cnt_r   <= '0;
        hold_cnt_r   <= '0;
        acc_r        <= '0;
        words_loaded <= '0;
        err          <= 1'b0;
        checksum     <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            cpu_rst  <= 1'b1;
            rom_sel  <= 1'b0;
            in_ready <= 1'b0;
          end
          LOAD: begin
            cpu_rst <= 1'b1;
            rom_sel <= 1'b1;
            if (word_done_s) begin
              acc_r      <= '0;
              byte_cnt_r <= '0;
              if (overflow_s) begin
                err <= 1'b1;
              end else begin
                rom_we       <= 1'b1;
                rom_addr     <= words_loaded[ADDR_W-1:0];
                rom_data     <= word_s;
                words_loaded <= words_loaded + (ADDR_W + 1)'(1);
                checksum     <= sum_next_s;
              end
              if (in_last) begin
                // rom_sel stays high through the write cycle on either path
                in_ready <= 1'b0;
                if (fail_s) begin
                  err     <= 1'b1;
                  state_r <= IDLE;
                end else begin
                  hold_cnt_r <= '0;
                  state_r    <= HOLD;
                end
              end else begin
                in_ready <= 1'b1;
              end
            end else if (accept_s) begin
              acc_r      <= word_s;
              byte_cnt_r <= byte_cnt_r + CNT_W'(1);
              in_ready   <= 1'b1;
            end else begin
              in_ready <= 1'b1;
            end
          end
          HOLD: begin
            in_ready <= 1'b0;
            if (hold_cnt_r == HOLD_END) begin
              state_r <= RUN;
              cpu_rst <= 1'b0;
              rom_sel <= 1'b0;
            end else begin
              hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
              cpu_rst    <= 1'b1;
              rom_sel    <= 1'b1;
            end
          end
          RUN: begin
            cpu_rst  <= 1'b0;
            rom_sel  <= 1'b0;
            in_ready <= 1'b0;
          end
          default: begin
            state_r  <= IDLE;
            cpu_rst  <= 1'b1;
            rom_sel  <= 1'b0;
            in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_program_loader.sv
// Directed self-checking bench for hack_program_loader (default parameters,
// plus a DEPTH=2 instance sharing the same stimulus for the overflow case).
module tb_hack_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] exp_sum = 16'h0000;

  logic        in_ready, rom_we, rom_sel, cpu_rst, err;
  logic [14:0] rom_addr;
  logic [15:0] rom_data, checksum;
  logic [15:0] words_loaded;

  logic        in_ready2, rom_we2, rom_sel2, cpu_rst2, err2;
  logic [14:0] rom_addr2;
  logic [15:0] rom_data2, checksum2;
  logic [15:0] words_loaded2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cyc = 0;
  int run_cyc = -1;
  logic cpu_rst_q = 1'b1;
  logic [31:0] wa[$], wd[$], wa2[$], wd2[$];
  logic [7:0] img[8];

  hack_program_loader u_dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .exp_sum(exp_sum), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_we(rom_we), .rom_sel(rom_sel), .cpu_rst(cpu_rst),
    .words_loaded(words_loaded), .err(err), .checksum(checksum)
  );

  hack_program_loader #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready2),
    .exp_sum(exp_sum), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .rom_we(rom_we2), .rom_sel(rom_sel2), .cpu_rst(cpu_rst2),
    .words_loaded(words_loaded2), .err(err2), .checksum(checksum2)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // ROM write capture and cpu_rst release timing
  always @(negedge clk) begin
    if (rom_we) begin
      wa.push_back(32'(rom_addr));
      wd.push_back(32'(rom_data));
      we_cyc = cyc;
    end
    if (rom_we2) begin
      wa2.push_back(32'(rom_addr2));
      wd2.push_back(32'(rom_data2));
    end
    if (cpu_rst_q && !cpu_rst) run_cyc = cyc;
    cpu_rst_q = cpu_rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    wa.delete(); wd.delete(); wa2.delete(); wd2.delete();
    run_cyc = -1;
  endtask

  task automatic start();
    clear_q();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    check("load_cpu_rst", 32'(cpu_rst), 32'd1);
    check("load_ready", 32'(in_ready), 32'd1);
    check("load_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic send(input int n, input bit gap, input bit mark_last);
    bit acc;
    for (int i = 0; i < n; i++) begin
      in_data  = img[i];
      in_last  = mark_last && (i == n - 1);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
      end
      check("byte_accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20 && cpu_rst; i++) @(negedge clk);
    check("reach_run", 32'(cpu_rst), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_addr"}, (i < wa.size()) ? wa[i] : 32'hDEAD_BEEF, a);
    check({tag, "_data"}, (i < wd.size()) ? wd[i] : 32'hDEAD_BEEF, d);
  endtask

  initial begin
    // reset values
    #12;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_rom_we", 32'(rom_we), 32'd0);
    check("rst_rom_sel", 32'(rom_sel), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rom_data", 32'(rom_data), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // even image
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'hAB; img[3] = 8'hCD;
    start();
    send(4, 1'b0, 1'b1);
    wait_run();
    check("even_nwr", 32'(wa.size()), 32'd2);
    wr("even_w0", 0, 32'd0, 32'h1234);
    wr("even_w1", 1, 32'd1, 32'hABCD);
    check("even_words", 32'(words_loaded), 32'd2);
    check("even_hold", 32'(run_cyc - we_cyc), 32'd4);
    check("even_err", 32'(err), 32'd0);
    check("even_rom_sel", 32'(rom_sel), 32'd0);

    // odd image, restarting from RUN
    img[2] = 8'h56;
    start();
    send(3, 1'b0, 1'b1);
    wait_run();
    check("odd_nwr", 32'(wa.size()), 32'd2);
    wr("odd_w0", 0, 32'd0, 32'h1234);
    wr("odd_w1", 1, 32'd1, 32'h5600);
    check("odd_words", 32'(words_loaded), 32'd2);

    // gapped valid over the even image
    img[2] = 8'hAB;
    start();
    send(4, 1'b1, 1'b1);
    wait_run();
    check("gap_nwr", 32'(wa.size()), 32'd2);
    wr("gap_w0", 0, 32'd0, 32'h1234);
    wr("gap_w1", 1, 32'd1, 32'hABCD);

    // overflow on the DEPTH=2 instance
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03;
    img[3] = 8'h04; img[4] = 8'h05; img[5] = 8'h06;
    start();
    send(6, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("ovf_nwr", 32'(wa2.size()), 32'd2);
    check("ovf_w0", (wd2.size() > 0) ? wd2[0] : 32'hDEAD_BEEF, 32'h0102);
    check("ovf_w1", (wd2.size() > 1) ? wd2[1] : 32'hDEAD_BEEF, 32'h0304);
    check("ovf_a1", (wa2.size() > 1) ? wa2[1] : 32'hDEAD_BEEF, 32'd1);
    check("ovf_err", 32'(err2), 32'd1);
    check("ovf_cpu_rst", 32'(cpu_rst2), 32'd1);
    check("ovf_rom_sel", 32'(rom_sel2), 32'd0);
    check("ovf_words", 32'(words_loaded2), 32'd2);
    check("big_nwr", 32'(wa.size()), 32'd3);
    check("big_cpu_rst", 32'(cpu_rst), 32'd0);

    // async reset mid-load
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
    start();
    send(3, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_rom_we", 32'(rom_we), 32'd0);
    check("arst_rom_sel", 32'(rom_sel), 32'd0);
    check("arst_words", 32'(words_loaded), 32'd0);
    check("arst_rom_data", 32'(rom_data), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    start();
    send(2, 1'b0, 1'b1);
    wait_run();
    check("arst_nwr", 32'(wa.size()), 32'd1);
    wr("arst_w0", 0, 32'd0, 32'h1234);
    check("arst_words2", 32'(words_loaded), 32'd1);

    // checksum image 0x0001, 0x0002
    img[0] = 8'h00; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h02;
`ifdef CHECKSUM_EN
    exp_sum = 16'h0003;
    start();
    send(4, 1'b0, 1'b1);
    wait_run();
    check("cs_ok_sum", 32'(checksum), 32'h0003);
    check("cs_ok_err", 32'(err), 32'd0);
    exp_sum = 16'h0004;
    start();
    send(4, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("cs_bad_err", 32'(err), 32'd1);
    check("cs_bad_cpu_rst", 32'(cpu_rst), 32'd1);
    check("cs_bad_rom_sel", 32'(rom_sel), 32'd0);
    check("cs_bad_nwr", 32'(wa.size()), 32'd2);
`else
    exp_sum = 16'h0004;
    start();
    send(4, 1'b0, 1'b1);
    wait_run();
    check("nocs_sum", 32'(checksum), 32'h0000);
    check("nocs_err", 32'(err), 32'd0);
    wr("nocs_w1", 1, 32'd1, 32'h0002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
